bp_train_driver: RTL and testbench

Retire-side producer of the branch-predictor training stream. Execute posts up to two resolved branch outcomes per cycle, and they are buffered in program order until retire commits them. For each committed outcome the block drives the dual-lane `train_valid*` / `isbranch*` / `address_branch*` / `address_result*` / `taken*` interface consumed by the gselect predictor. It also detects target mispredictions at retire, then issues a front-end redirect and flushes younger queued outcomes.

---
 rtl/bp_pkg.sv | 39 +++
 rtl/bp_train_driver_if.sv | 54 +++++
 rtl/bp_train_fifo.sv | 66 ++++++
 rtl/bp_train_driver.sv | 144 ++++++++++++++
 tb/tb_bp_train_driver.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor training driver.
package bp_pkg;

  localparam int AW = 32;
  localparam logic [AW-1:0] PC_INC = AW'(4);

  // One resolved outcome waiting for retire; mis is precomputed at enqueue.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic          isbranch;
    logic          taken;
    logic [AW-1:0] target;
    logic          mis;
  } bp_entry_t;

  // Architecturally correct next PC for a resolved instruction.
  function automatic logic [AW-1:0] bp_actual_next(input bp_entry_t e);
    return (e.isbranch && e.taken) ? e.target : (e.pc + PC_INC);
  endfunction

  // Build a queue entry from execute-side fields, flagging a target mispredict.
  function automatic bp_entry_t bp_make_entry(
    input logic [AW-1:0] pc,
    input logic          isbranch,
    input logic          taken,
    input logic [AW-1:0] target,
    input logic [AW-1:0] pred
  );
    bp_entry_t e;
    e.pc       = pc;
    e.isbranch = isbranch;
    e.taken    = taken;
    e.target   = target;
    e.mis      = 1'b0;
    e.mis      = (bp_actual_next(e) != pred);
    return e;
  endfunction

endpackage

// File: rtl/bp_train_driver_if.sv
// Execute/retire-facing bus of the training driver: resolved outcomes in,
// predictor training pulses and front-end redirect out.
interface bp_train_driver_if;
  import bp_pkg::*;

  logic          res_valid0;
  logic          res_valid1;
  logic [AW-1:0] res_pc0;
  logic [AW-1:0] res_pc1;
  logic          res_isbranch0;
  logic          res_isbranch1;
  logic          res_taken0;
  logic          res_taken1;
  logic [AW-1:0] res_target0;
  logic [AW-1:0] res_target1;
  logic [AW-1:0] res_pred0;
  logic [AW-1:0] res_pred1;
  logic          res_ready;
  logic [1:0]    retire_cnt;
  logic          flush;
  logic          train_valid0;
  logic          train_valid1;
  logic          isbranch0;
  logic          isbranch1;
  logic          taken0;
  logic          taken1;
  logic [AW-1:0] address_branch0;
  logic [AW-1:0] address_branch1;
  logic [AW-1:0] address_result0;
  logic [AW-1:0] address_result1;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;

  modport master (
    output res_valid0, res_valid1, res_pc0, res_pc1,
           res_isbranch0, res_isbranch1, res_taken0, res_taken1,
           res_target0, res_target1, res_pred0, res_pred1,
           retire_cnt, flush,
    input  res_ready, train_valid0, train_valid1, isbranch0, isbranch1,
           taken0, taken1, address_branch0, address_branch1,
           address_result0, address_result1, redirect_valid, redirect_pc
  );

  modport slave (
    input  res_valid0, res_valid1, res_pc0, res_pc1,
           res_isbranch0, res_isbranch1, res_taken0, res_taken1,
           res_target0, res_target1, res_pred0, res_pred1,
           retire_cnt, flush,
    output res_ready, train_valid0, train_valid1, isbranch0, isbranch1,
           taken0, taken1, address_branch0, address_branch1,
           address_result0, address_result1, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/bp_train_fifo.sv
// Two-write / two-read circular buffer of resolved outcomes. The caller
// guarantees space for writes and never reads more than count.
module bp_train_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    wr_cnt_i,
  input  bp_entry_t     wr_data0_i,
  input  bp_entry_t     wr_data1_i,
  input  logic [1:0]    rd_cnt_i,
  input  logic          clr_i,
  output bp_entry_t     rd_data0_o,
  output bp_entry_t     rd_data1_o,
  output logic [CW-1:0] count_o
);

  bp_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_p1;
  logic [CW-1:0] count_q, count_d;

  // Power-of-two depth lets pointer arithmetic wrap for free.
  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);

  // Next pointers/count; a clear empties the queue and drops this cycle's writes.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + PW'(rd_cnt_i);
    count_d  = count_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: lane-ordered writes at tail and tail+1.
  always_ff @(posedge clk) begin
    if (!clr_i && (wr_cnt_i != 2'd0)) mem_q[wr_ptr_q]  <= wr_data0_i;
    if (!clr_i && (wr_cnt_i == 2'd2)) mem_q[wr_ptr_p1] <= wr_data1_i;
  end

  assign rd_data0_o = mem_q[rd_ptr_q];
  assign rd_data1_o = mem_q[rd_ptr_p1];
  assign count_o    = count_q;

endmodule

// File: rtl/bp_train_driver.sv
// Retire-side producer of the gselect training stream: buffers resolved
// outcomes in program order, trains on commit, redirects on mispredict.
module bp_train_driver
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bp_train_driver_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  bp_entry_t     enq_e0, enq_e1;
  bp_entry_t     wr_d0, wr_d1;
  bp_entry_t     head0, head1;
  logic [CW-1:0] count;
  logic          ready;
  logic [1:0]    wr_cnt;
  logic [1:0]    ret_req;
  logic [1:0]    rd_cnt;
  logic [1:0]    lane_train;
  logic          mis_hit;
  logic          clr;
  logic [AW-1:0] redir_pc;
  logic          redirect_valid_q;
  logic [AW-1:0] redirect_pc_q;

  assign enq_e0 = bp_make_entry(bus.res_pc0, bus.res_isbranch0, bus.res_taken0,
                                bus.res_target0, bus.res_pred0);
  assign enq_e1 = bp_make_entry(bus.res_pc1, bus.res_isbranch1, bus.res_taken1,
                                bus.res_target1, bus.res_pred1);

  // Ready only when both lanes are guaranteed a slot.
  assign ready         = (CW'(DEPTH) - count) >= CW'(2);
  assign bus.res_ready = ready;

  // Enqueue: compact a lone lane-1 outcome down to the tail slot.
  always_comb begin
    wr_cnt = 2'd0;
    wr_d0  = enq_e1;
    wr_d1  = enq_e1;
    if (ready) begin
      if (bus.res_valid0) begin
        wr_d0  = enq_e0;
        wr_cnt = bus.res_valid1 ? 2'd2 : 2'd1;
      end else if (bus.res_valid1) begin
        wr_cnt = 2'd1;
      end
    end
  end

  // Retire count: 3 means 2, and never pop more than is queued.
  always_comb begin
    ret_req = (bus.retire_cnt == 2'd3) ? 2'd2 : bus.retire_cnt;
    rd_cnt  = ret_req;
    if (CW'(ret_req) > count) rd_cnt = count[1:0];
  end

  bp_train_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_cnt_i   (wr_cnt),
    .wr_data0_i (wr_d0),
    .wr_data1_i (wr_d1),
    .rd_cnt_i   (rd_cnt),
    .clr_i      (clr),
    .rd_data0_o (head0),
    .rd_data1_o (head1),
    .count_o    (count)
  );

  // Oldest mispredict wins: it still trains, younger lane is suppressed.
  always_comb begin
    lane_train[0] = (rd_cnt != 2'd0);
    lane_train[1] = (rd_cnt == 2'd2) && !head0.mis;
    mis_hit       = 1'b0;
    redir_pc      = bp_actual_next(head0);
    if (lane_train[0] && head0.mis) begin
      mis_hit = 1'b1;
    end else if (lane_train[1] && head1.mis) begin
      mis_hit  = 1'b1;
      redir_pc = bp_actual_next(head1);
    end
  end

  // Either a mispredict or an external flush empties the queue.
  assign clr = bus.flush | mis_hit;

  // Per-lane registered training outputs.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    bp_entry_t     e;
    logic          tv_q;
    logic          isb_q;
    logic          tk_q;
    logic [AW-1:0] ab_q;
    logic [AW-1:0] ar_q;

    assign e = (gi == 0) ? head0 : head1;

    // One-cycle training pulse carrying the popped entry for this lane.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tv_q  <= 1'b0;
        isb_q <= 1'b0;
        tk_q  <= 1'b0;
        ab_q  <= '0;
        ar_q  <= '0;
      end else begin
        tv_q  <= lane_train[gi];
        isb_q <= lane_train[gi] & e.isbranch;
        tk_q  <= lane_train[gi] & e.isbranch & e.taken;
        ab_q  <= lane_train[gi] ? e.pc : '0;
        ar_q  <= lane_train[gi] ? e.target : '0;
      end
    end
  end

  // Redirect register; an external flush owns the front end, so no redirect then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= mis_hit & ~bus.flush;
      redirect_pc_q    <= (mis_hit & ~bus.flush) ? redir_pc : '0;
    end
  end

  assign bus.train_valid0    = g_lane[0].tv_q;
  assign bus.train_valid1    = g_lane[1].tv_q;
  assign bus.isbranch0       = g_lane[0].isb_q;
  assign bus.isbranch1       = g_lane[1].isb_q;
  assign bus.taken0          = g_lane[0].tk_q;
  assign bus.taken1          = g_lane[1].tk_q;
  assign bus.address_branch0 = g_lane[0].ab_q;
  assign bus.address_branch1 = g_lane[1].ab_q;
  assign bus.address_result0 = g_lane[0].ar_q;
  assign bus.address_result1 = g_lane[1].ar_q;
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_pc     = redirect_pc_q;

endmodule

// File: tb/tb_bp_train_driver.sv
// Randomized + directed bench for bp_train_driver against a queue-based model.
module tb_bp_train_driver;
  import bp_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_train_driver_if bus_if();

  bp_train_driver #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [31:0] pc;
    bit          isb;
    bit          tk;
    logic [31:0] tgt;
    logic [31:0] pred;
  } br_t;

  br_t mq[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  br_t in0, in1;
  bit  v0, v1, fl;
  int  rc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] next_of(input br_t b);
    return (b.isb && b.tk) ? b.tgt : b.pc + 32'd4;
  endfunction

  function automatic br_t mk(input logic [31:0] pc, input bit isb, input bit tk,
                             input logic [31:0] tgt, input logic [31:0] pred);
    br_t b;
    b.pc = pc; b.isb = isb; b.tk = tk; b.tgt = tgt; b.pred = pred;
    return b;
  endfunction

  function automatic br_t rnd_br();
    br_t b;
    b.pc   = $urandom() & 32'hFFFF_FFFC;
    b.isb  = ($urandom_range(0, 3) != 0);
    b.tk   = $urandom_range(0, 1);
    b.tgt  = $urandom() & 32'hFFFF_FFFC;
    b.pred = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : next_of(b);
    return b;
  endfunction

  task automatic idle();
    v0 = 0; v1 = 0; rc = 0; fl = 0;
  endtask

  task automatic apply();
    bus_if.res_valid0    = v0;
    bus_if.res_valid1    = v1;
    bus_if.res_pc0       = in0.pc;
    bus_if.res_pc1       = in1.pc;
    bus_if.res_isbranch0 = in0.isb;
    bus_if.res_isbranch1 = in1.isb;
    bus_if.res_taken0    = in0.tk;
    bus_if.res_taken1    = in1.tk;
    bus_if.res_target0   = in0.tgt;
    bus_if.res_target1   = in1.tgt;
    bus_if.res_pred0     = in0.pred;
    bus_if.res_pred1     = in1.pred;
    bus_if.retire_cnt    = 2'(rc);
    bus_if.flush         = fl;
  endtask

  // One clock: predict from the model, advance, compare, update the model.
  task automatic cycle();
    int n, sz;
    bit ready, tv0, tv1, red;
    logic [31:0] rpc;
    br_t e0, e1;
    apply();
    sz = mq.size();
    ready = (DEPTH - sz) >= 2;
    chk("res_ready", bus_if.res_ready, ready);
    n = (rc > 2) ? 2 : rc;
    if (n > sz) n = sz;
    tv0 = (n >= 1); tv1 = 0; red = 0; rpc = 0;
    if (tv0) begin
      e0 = mq[0];
      if (next_of(e0) != e0.pred) begin red = 1; rpc = next_of(e0); end
    end
    if (n == 2 && !red) begin
      e1 = mq[1];
      tv1 = 1;
      if (next_of(e1) != e1.pred) begin red = 1; rpc = next_of(e1); end
    end
    @(posedge clk); #1;
    $display("[TB] cyc v=%0d%0d rc=%0d fl=%0d q=%0d -> tv=%0d%0d red=%0d",
             v0, v1, rc, fl, sz, bus_if.train_valid0, bus_if.train_valid1, bus_if.redirect_valid);
    chk("train_valid0", bus_if.train_valid0, tv0);
    chk("train_valid1", bus_if.train_valid1, tv1);
    chk("redirect_valid", bus_if.redirect_valid, red && !fl);
    if (tv0) begin
      chk("address_branch0", bus_if.address_branch0, e0.pc);
      chk("address_result0", bus_if.address_result0, e0.tgt);
      chk("taken0", bus_if.taken0, e0.isb && e0.tk);
      chk("isbranch0", bus_if.isbranch0, e0.isb);
    end
    if (tv1) begin
      chk("address_branch1", bus_if.address_branch1, e1.pc);
      chk("address_result1", bus_if.address_result1, e1.tgt);
      chk("taken1", bus_if.taken1, e1.isb && e1.tk);
      chk("isbranch1", bus_if.isbranch1, e1.isb);
    end
    if (red && !fl) chk("redirect_pc", bus_if.redirect_pc, rpc);
    for (int i = 0; i < n; i++) void'(mq.pop_front());
    if (red || fl) mq.delete();
    else if (ready) begin
      if (v0) mq.push_back(in0);
      if (v1) mq.push_back(in1);
    end
  endtask

  initial begin
    in0 = rnd_br(); in1 = rnd_br();
    idle();
    v0 = 1;
    apply();
    // Reset held with a valid outcome on lane 0.
    #12;
    chk("rst_train_valid0", bus_if.train_valid0, 1'b0);
    chk("rst_train_valid1", bus_if.train_valid1, 1'b0);
    chk("rst_redirect_valid", bus_if.redirect_valid, 1'b0);
    chk("rst_res_ready", bus_if.res_ready, 1'b1);
    idle(); apply();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rc = 2; cycle(); idle();

    // Correct pair.
    in0 = mk(32'h100, 1, 1, 32'h200, 32'h200);
    in1 = mk(32'h104, 1, 0, 32'h180, 32'h108);
    v0 = 1; v1 = 1; cycle(); idle();
    rc = 2; cycle(); idle();
    chk("pair_ab0", bus_if.address_branch0, 32'h100);
    chk("pair_ar0", bus_if.address_result0, 32'h200);
    chk("pair_ab1", bus_if.address_branch1, 32'h104);

    // Lane-0 mispredict with younger entries queued.
    in0 = mk(32'h300, 1, 1, 32'h400, 32'h304);
    in1 = mk(32'h308, 1, 0, 32'h500, 32'h30C);
    v0 = 1; v1 = 1; cycle();
    in0 = mk(32'h30C, 0, 0, 32'h0, 32'h310);
    in1 = mk(32'h310, 0, 0, 32'h0, 32'h314);
    cycle(); idle();
    rc = 2; cycle(); idle();
    chk("mis_redirect_pc", bus_if.redirect_pc, 32'h400);
    chk("mis_train_valid1", bus_if.train_valid1, 1'b0);
    rc = 2; cycle(); idle();

    // Fill to full, try one more pair, then free two slots.
    for (int k = 0; k < 5; k++) begin
      in0 = mk(32'h2000 + 8*k, 0, 0, 32'h0, 32'h2004 + 8*k);
      in1 = mk(32'h2004 + 8*k, 0, 0, 32'h0, 32'h2008 + 8*k);
      v0 = 1; v1 = 1; cycle();
    end
    idle();
    chk("full_res_ready", bus_if.res_ready, 1'b0);
    rc = 2; cycle(); idle();
    chk("after_retire_ready", bus_if.res_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin rc = 2; cycle(); end
    idle();

    // Streaming across pointer wrap, one in / one out per cycle.
    for (int k = 0; k < 20; k++) begin
      in0 = mk(32'h1000 + 4*k, 0, 0, 32'h0, 32'h1004 + 4*k);
      v0 = 1; rc = 1; cycle();
    end
    idle(); rc = 2; cycle(); cycle(); idle();

    // External flush with five queued and a single retire.
    for (int k = 0; k < 3; k++) begin
      in0 = mk(32'h3000 + 8*k, 0, 0, 32'h0, 32'h3004 + 8*k);
      in1 = mk(32'h3004 + 8*k, 0, 0, 32'h0, 32'h3008 + 8*k);
      v0 = 1; v1 = (k < 2); cycle();
    end
    idle();
    fl = 1; rc = 1; cycle(); idle();
    rc = 2; cycle(); idle();

    // Asynchronous reset while a training pulse is live and entries remain.
    for (int k = 0; k < 2; k++) begin
      in0 = mk(32'h4000 + 8*k, 0, 0, 32'h0, 32'h4004 + 8*k);
      in1 = mk(32'h4004 + 8*k, 0, 0, 32'h0, 32'h4008 + 8*k);
      v0 = 1; v1 = 1; cycle();
    end
    idle(); rc = 2; cycle(); idle(); apply();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tv0", bus_if.train_valid0, 1'b0);
    chk("async_rst_ready", bus_if.res_ready, 1'b1);
    mq.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rc = 2; cycle(); idle();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      in0 = rnd_br(); in1 = rnd_br();
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      rc = $urandom_range(0, 3);
      fl = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle(); apply();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
